ads131a0x_sample_ring_ram: RTL and testbench

Parametrised successor to the ADC on-chip sample RAM. It adds a streaming write port that captures ADS131A0X channel frames into a circular buffer, keeping per-frame level and overflow accounting. An Avalon-MM data slave provides CPU access with a configurable read latency, and a small CSR slave handles control and buffer release. The block sits between the ADS131A0X SPI frame decoder and the Nios II data bus, replacing the flat RAM.

---
 rtl/ads131a0x_sample_ring_ram_if.sv | 47 ++++
 rtl/ads131a0x_sample_ring_ram.sv | 214 +++++++++++++++++++++
 tb/tb_ads131a0x_sample_ring_ram.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads131a0x_sample_ring_ram_if.sv
// Bus bundle for the ADS131A0X sample ring RAM: frame stream sink,
// Avalon-MM data slave (s1), CSR slave and the interrupt line.
interface ads131a0x_sample_ring_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  // Sample stream from the SPI frame decoder
  logic                    snk_valid;
  logic                    snk_sop;
  logic [DATA_WIDTH-1:0]   snk_data;
  // Avalon-MM data slave
  logic [ADDR_WIDTH-1:0]   s1_address;
  logic                    s1_chipselect;
  logic                    s1_read;
  logic                    s1_write;
  logic [DATA_WIDTH/8-1:0] s1_byteenable;
  logic [DATA_WIDTH-1:0]   s1_writedata;
  logic [DATA_WIDTH-1:0]   s1_readdata;
  logic                    s1_readdatavalid;
  logic                    s1_waitrequest;
  // CSR slave
  logic [1:0]              csr_address;
  logic                    csr_read;
  logic                    csr_write;
  logic [31:0]             csr_writedata;
  logic [31:0]             csr_readdata;
  // Interrupt
  logic                    irq;

  // Side that drives the stream and issues bus accesses
  modport master (
    output snk_valid, snk_sop, snk_data,
    output s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
    input  s1_readdata, s1_readdatavalid, s1_waitrequest,
    output csr_address, csr_read, csr_write, csr_writedata,
    input  csr_readdata, irq
  );

  // The ring RAM itself
  modport slave (
    input  snk_valid, snk_sop, snk_data,
    input  s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
    output s1_readdata, s1_readdatavalid, s1_waitrequest,
    input  csr_address, csr_read, csr_write, csr_writedata,
    output csr_readdata, irq
  );
endinterface

// File: rtl/ads131a0x_sample_ring_ram.sv
// Circular sample buffer for ADS131A0X channel frames. Stream writes have
// priority on the single-port RAM; the CPU reads/writes through s1 and
// manages level, release and status through the CSR slave.
module ads131a0x_sample_ring_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 10240,
  parameter int ADDR_WIDTH   = 14,
  parameter int CHANNELS     = 4,
  parameter int READ_LATENCY = 1
) (
  input logic                        clk,
  input logic                        reset,
  ads131a0x_sample_ring_ram_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [31:0]      DEPTH_U   = 32'(DEPTH);
  localparam logic [LVL_W-1:0] OVF_LIMIT = LVL_W'(DEPTH - CHANNELS);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHANNELS - 1);

  // Frame capture states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, ferr_q;
  logic [15:0]      drop_cnt_q;
  logic             enable_q, irq_en_q, irq_q;
  logic [15:0]      threshold_q;
  logic [31:0]      csr_rd_q, csr_mux;

  logic             stream_wr, set_ferr, set_ovf;
  logic             ctrl_wr, rel_wr, stat_wr, clear_req;
  logic [31:0]      level_32, rel_32, rd_sum;

  logic                  s1_access, s1_in_range, cpu_rd, cpu_wr;
  logic [PTR_W-1:0]      s1_idx;
  logic [DATA_WIDTH-1:0] ram_q, stage1_data;
  logic                  rd_vld1_q, rd_zero_q;

  assign ctrl_wr   = bus.csr_write && (bus.csr_address == 2'd0);
  assign rel_wr    = bus.csr_write && (bus.csr_address == 2'd2);
  assign stat_wr   = bus.csr_write && (bus.csr_address == 2'd3);
  assign clear_req = ctrl_wr && bus.csr_writedata[2];
  assign level_32  = 32'(level_q);

  // Frame FSM: decide whether the incoming sample is written, dropped or a framing error
  // NOTE: every output of an always_comb gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stream_wr = 1'b0;
    set_ferr  = 1'b0;
    set_ovf   = 1'b0;
    if (bus.snk_valid && enable_q) begin
      if (bus.snk_sop) begin
        // An sop mid-fill aborts that frame; a frame being dropped ends quietly
        if (state_q == ST_FILL) set_ferr = 1'b1;
        idx_d = IDX_W'(1);
        if (level_q > OVF_LIMIT) begin
          set_ovf = 1'b1;
          state_d = (CHANNELS > 1) ? ST_DROP : ST_IDLE;
        end else begin
          stream_wr = 1'b1;
          state_d   = (CHANNELS > 1) ? ST_FILL : ST_IDLE;
        end
      end else if (state_q == ST_IDLE) begin
        set_ferr = 1'b1;
      end else begin
        stream_wr = (state_q == ST_FILL);
        idx_d     = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = ST_IDLE;
      end
    end
  end

  // Release amount clipped to the current level, and the wrapped read pointer
  always_comb begin
    rel_32 = '0;
    if (rel_wr) rel_32 = (bus.csr_writedata < level_32) ? bus.csr_writedata : level_32;
    rd_sum = 32'(rd_ptr_q) + rel_32;
    if (rd_sum >= DEPTH_U) rd_sum = rd_sum - DEPTH_U;
    level_d = level_q + LVL_W'(stream_wr) - LVL_W'(rel_32);
  end

  // Ring pointers, level, frame state and status; clear acts like a reset of these
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear_req) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ferr_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      rd_ptr_q   <= PTR_W'(rd_sum);
      if (stream_wr) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      // A new event in the same cycle as its W1C wins
      overflow_q <= set_ovf  | (overflow_q & ~(stat_wr & bus.csr_writedata[0]));
      ferr_q     <= set_ferr | (ferr_q & ~(stat_wr & bus.csr_writedata[1]));
      if (stat_wr && bus.csr_writedata[0]) drop_cnt_q <= set_ovf ? 16'd1 : 16'd0;
      else if (set_ovf && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // CTRL register; the clear bit is a strobe and is not stored
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      threshold_q <= '0;
    end else if (ctrl_wr) begin
      enable_q    <= bus.csr_writedata[0];
      irq_en_q    <= bus.csr_writedata[1];
      threshold_q <= bus.csr_writedata[31:16];
    end
  end

  // CSR read mux
  always_comb begin
    csr_mux = '0;
    case (bus.csr_address)
      2'd0:    csr_mux = {threshold_q, 13'd0, 1'b0, irq_en_q, enable_q};
      2'd1:    csr_mux = 32'(wr_ptr_q);
      2'd2:    csr_mux = level_32;
      default: csr_mux = {drop_cnt_q, 14'd0, ferr_q, overflow_q};
    endcase
  end

  // CSR read data and interrupt, both registered
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_rd_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (bus.csr_read) csr_rd_q <= csr_mux;
      irq_q <= irq_en_q && (overflow_q || (level_32 >= 32'(threshold_q)));
    end
  end

  assign bus.csr_readdata = csr_rd_q;
  assign bus.irq          = irq_q;

  // s1 arbitration: the stream owns the RAM port in any cycle it writes
  assign s1_access          = bus.s1_chipselect && (bus.s1_read || bus.s1_write);
  assign bus.s1_waitrequest = s1_access && stream_wr;
  assign s1_in_range        = 32'(bus.s1_address) < DEPTH_U;
  assign s1_idx             = bus.s1_address[PTR_W-1:0];
  assign cpu_rd             = bus.s1_chipselect && bus.s1_read && !stream_wr;
  assign cpu_wr             = bus.s1_chipselect && bus.s1_write && !stream_wr && s1_in_range;

  // Single-port sample RAM: stream write, else CPU byte-lane write, plus CPU read
  // NOTE: the RAM array has no reset; the read-valid flops below qualify its output instead.
  always_ff @(posedge clk) begin
    if (stream_wr) begin
      mem[wr_ptr_q] <= bus.snk_data;
    end else if (cpu_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= bus.s1_writedata[b*8 +: 8];
      end
    end
    if (cpu_rd && s1_in_range) ram_q <= mem[s1_idx];
  end

  // First read stage: valid flag and out-of-range marker
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld1_q <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      rd_vld1_q <= cpu_rd;
      rd_zero_q <= !s1_in_range;
    end
  end

  assign stage1_data = (rd_vld1_q && !rd_zero_q) ? ram_q : '0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] data2_q;
      logic                  vld2_q;
      // Extra output register stage
      always_ff @(posedge clk) begin
        if (reset) begin
          data2_q <= '0;
          vld2_q  <= 1'b0;
        end else begin
          data2_q <= stage1_data;
          vld2_q  <= rd_vld1_q;
        end
      end
      assign bus.s1_readdata      = data2_q;
      assign bus.s1_readdatavalid = vld2_q;
    end else begin : g_lat1
      assign bus.s1_readdata      = stage1_data;
      assign bus.s1_readdatavalid = rd_vld1_q;
    end
  endgenerate
endmodule

// File: tb/tb_ads131a0x_sample_ring_ram.sv
// Directed + randomized bench for ads131a0x_sample_ring_ram (DEPTH=16, CHANNELS=4).
module tb_ads131a0x_sample_ring_ram;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int CH    = 4;
  localparam int RL    = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ads131a0x_sample_ring_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ads131a0x_sample_ring_ram #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CHANNELS(CH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: ring contents plus the accounting rules in plain arithmetic
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int m_wr, m_rd, m_level, m_pos, m_dropcnt, m_thr;
  bit m_drop, m_ovf, m_ferr, m_en, m_irqen;

  function automatic void m_clear();
    m_wr = 0; m_rd = 0; m_level = 0; m_pos = -1;
    m_drop = 0; m_ovf = 0; m_ferr = 0; m_dropcnt = 0;
  endfunction

  // One accepted sample (enable already known to be set)
  function automatic void m_sample(bit sop, logic [31:0] d);
    if (sop) begin
      if (m_pos >= 0 && !m_drop) m_ferr = 1;
      m_pos  = 0;
      m_drop = (m_level > DEPTH - CH);
      if (m_drop) begin
        m_ovf = 1;
        if (m_dropcnt < 65535) m_dropcnt++;
      end
    end else if (m_pos < 0) begin
      m_ferr = 1;
      return;
    end
    if (!m_drop) begin
      m_mem[m_wr] = d;
      m_known[m_wr] = 1;
      m_wr = (m_wr + 1) % DEPTH;
      m_level++;
    end
    m_pos++;
    if (m_pos == CH) m_pos = -1;
  endfunction

  function automatic int m_rel_amount(int n);
    return (n < m_level) ? n : m_level;
  endfunction

  function automatic logic [31:0] m_status();
    return {m_dropcnt[15:0], 14'd0, m_ferr, m_ovf};
  endfunction

  function automatic logic [31:0] m_irq();
    return 32'(m_irqen && (m_ovf || m_level >= m_thr));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sop, input logic [31:0] d);
    bus.snk_valid = 1'b1;
    bus.snk_sop   = sop;
    bus.snk_data  = d;
    tick();
    if (m_en) m_sample(sop, d);
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
  endtask

  task automatic push_frame();
    for (int s = 0; s < CH; s++) push(s == 0, $urandom);
  endtask

  task automatic csr_wr(input int addr, input logic [31:0] d);
    int rel;
    rel = m_rel_amount(int'(d));
    bus.csr_address = 2'(addr); bus.csr_writedata = d; bus.csr_write = 1'b1;
    tick();
    bus.csr_write = 1'b0;
    case (addr)
      0: begin
        m_en = d[0]; m_irqen = d[1]; m_thr = int'(d[31:16]);
        if (d[2]) m_clear();
      end
      2: begin m_level -= rel; m_rd = (m_rd + rel) % DEPTH; end
      3: begin
        if (d[0]) begin m_ovf = 0; m_dropcnt = 0; end
        if (d[1]) m_ferr = 0;
      end
      default: ;
    endcase
  endtask

  task automatic csr_rd(input int addr, output logic [31:0] d);
    bus.csr_address = 2'(addr); bus.csr_read = 1'b1;
    tick();
    bus.csr_read = 1'b0;
    d = bus.csr_readdata;
  endtask

  task automatic check_csr(input string tag, input int addr, input logic [31:0] exp);
    logic [31:0] r;
    csr_rd(addr, r);
    check(tag, r, exp);
  endtask

  // s1 read with waitrequest retry; lat counts cycles from acceptance to readdatavalid
  task automatic s1_read(input int addr, output logic [31:0] d, output int lat);
    bit w;
    int guard = 0;
    bus.s1_chipselect = 1'b1; bus.s1_read = 1'b1; bus.s1_address = AW'(addr);
    do begin
      #1 w = bus.s1_waitrequest;
      tick();
      guard++;
    end while (w && guard < 8);
    bus.s1_chipselect = 1'b0; bus.s1_read = 1'b0;
    lat = 1;
    while (!bus.s1_readdatavalid && lat < 8) begin
      tick();
      lat++;
    end
    d = bus.s1_readdata;
  endtask

  task automatic s1_check(input string tag, input int addr);
    logic [31:0] d;
    int lat;
    s1_read(addr, d, lat);
    check({tag, "_data"}, d, (addr < DEPTH) ? m_mem[addr] : 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'(RL));
  endtask

  task automatic s1_write(input int addr, input logic [31:0] d, input logic [3:0] be);
    bus.s1_chipselect = 1'b1; bus.s1_write = 1'b1; bus.s1_address = AW'(addr);
    bus.s1_writedata = d; bus.s1_byteenable = be;
    tick();
    bus.s1_chipselect = 1'b0; bus.s1_write = 1'b0;
    if (addr < DEPTH)
      for (int b = 0; b < 4; b++) if (be[b]) m_mem[addr][b*8 +: 8] = d[b*8 +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, wd;
    logic [31:0] got[$];
    int lat, n, rel, wr_before;
    bit v, sop, rq;

    reset = 1'b1;
    bus.snk_valid = 0; bus.snk_sop = 0; bus.snk_data = '0;
    bus.s1_address = '0; bus.s1_chipselect = 0; bus.s1_read = 0; bus.s1_write = 0;
    bus.s1_byteenable = '0; bus.s1_writedata = '0;
    bus.csr_address = '0; bus.csr_read = 0; bus.csr_write = 0; bus.csr_writedata = '0;
    m_clear(); m_en = 0; m_irqen = 0; m_thr = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", bus.s1_readdata, 0);
    check("rst_rdvalid", 32'(bus.s1_readdatavalid), 0);
    check("rst_waitreq", 32'(bus.s1_waitrequest), 0);
    check("rst_csr_readdata", bus.csr_readdata, 0);
    check("rst_irq", 32'(bus.irq), 0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) check_csr("rst_csr", a, 0);

    // Three frames 0x100..0x10B, read back with latency check
    csr_wr(0, 32'h1);
    for (int i = 0; i < 3 * CH; i++) push((i % CH) == 0, 32'h100 + i);
    check_csr("fill_wrptr", 1, 12);
    check_csr("fill_level", 2, 12);
    for (int a = 0; a < 12; a++) begin
      s1_read(a, r, lat);
      check("fill_rd_data", r, 32'h100 + a);
      check("fill_rd_lat", 32'(lat), 32'(RL));
    end
    // Pipelined back-to-back reads, one result per cycle
    for (int c = 0; c < 4 + RL + 1; c++) begin
      if (c < 4) begin
        bus.s1_chipselect = 1; bus.s1_read = 1; bus.s1_address = AW'(8 + c);
      end else begin
        bus.s1_chipselect = 0; bus.s1_read = 0;
      end
      tick();
      if (bus.s1_readdatavalid) got.push_back(bus.s1_readdata);
    end
    check("burst_count", 32'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("burst_data", got[i], 32'h108 + i);

    // Release and wrap
    csr_wr(2, 12);
    check_csr("rel_level", 2, 0);
    push_frame(); push_frame();
    check_csr("wrap_wrptr", 1, 4);
    check_csr("wrap_level", 2, 8);
    for (int a = 12; a < 16; a++) s1_check("wrap_hi", a);
    for (int a = 0; a < 4; a++) s1_check("wrap_lo", a);

    // Overflow: level 12 still accepts a frame, level 13 drops one
    push_frame(); push_frame();
    check_csr("full_level", 2, 16);
    csr_wr(2, 3);
    check_csr("ovf_pre_level", 2, 13);
    csr_wr(0, 32'hFFFF_0003);
    tick();
    check("ovf_irq_before", 32'(bus.irq), m_irq());
    wr_before = m_wr;
    push_frame();
    check_csr("ovf_level", 2, 13);
    check_csr("ovf_status", 3, 32'h0001_0001);
    check_csr("ovf_wrptr", 1, 32'(wr_before));
    check("ovf_irq", 32'(bus.irq), 1);
    csr_wr(3, 32'h1);
    check_csr("w1c_status", 3, 0);
    check("irq_after_w1c", 32'(bus.irq), 0);
    csr_wr(2, 100);
    check_csr("rel_clip_level", 2, 0);

    // Framing: aborted partial frame then a full one, then stray sample in IDLE
    push(1, $urandom); push(0, $urandom);
    push_frame();
    check_csr("frm_status", 3, 32'h2);
    check_csr("frm_level", 2, 6);
    wr_before = m_wr;
    push(0, $urandom);
    check_csr("idle_level", 2, 6);
    check_csr("idle_wrptr", 1, 32'(wr_before));
    check_csr("idle_status", 3, m_status());
    // Threshold boundary for irq
    csr_wr(0, {16'd6, 16'h3});
    tick();
    check("irq_thr_eq", 32'(bus.irq), m_irq());
    csr_wr(0, {16'd7, 16'h3});
    tick();
    check("irq_thr_above", 32'(bus.irq), m_irq());
    csr_wr(0, 32'h1);
    csr_wr(3, 32'h2);
    check_csr("frm_w1c", 3, 0);

    // Arbitration: s1 read coincident with a stream write
    bus.snk_valid = 1; bus.snk_sop = 1; wd = $urandom; bus.snk_data = wd;
    bus.s1_chipselect = 1; bus.s1_read = 1; bus.s1_address = AW'(13);
    #1 check("arb_wait", 32'(bus.s1_waitrequest), 1);
    tick();
    m_sample(1, wd);
    bus.snk_valid = 0; bus.snk_sop = 0;
    #1 check("arb_wait_clear", 32'(bus.s1_waitrequest), 0);
    tick();
    bus.s1_chipselect = 0; bus.s1_read = 0;
    lat = 1;
    while (!bus.s1_readdatavalid && lat < 8) begin tick(); lat++; end
    check("arb_lat", 32'(lat), 32'(RL));
    check("arb_data", bus.s1_readdata, m_mem[13]);
    for (int s = 1; s < CH; s++) push(0, $urandom);
    check_csr("arb_level", 2, 32'(m_level));

    // CPU writes: byte lanes, write-then-read, out of range
    s1_write(5, 32'hA5B6_C7D8, 4'b0101);
    s1_check("be_rd", 5);
    s1_write(20, 32'hDEAD_BEEF, 4'hF);
    s1_check("oor_rd", 20);
    check_csr("cpu_wr_level", 2, 32'(m_level));

    // Clear in the middle of a frame
    push(1, $urandom); push(0, $urandom);
    csr_wr(0, 32'h5);
    check_csr("clr_level", 2, 0);
    check_csr("clr_wrptr", 1, 0);
    push(0, $urandom);
    check_csr("clr_status", 3, 32'h2);
    check_csr("clr_level2", 2, 0);
    s1_check("clr_ram_kept", 3);

    // Reset in the middle of a frame
    push(1, $urandom); push(0, $urandom);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_clear(); m_en = 0; m_irqen = 0; m_thr = 0;
    for (int a = 0; a < 4; a++) check_csr("rst2_csr", a, 0);
    csr_wr(0, 32'h1);
    push(0, $urandom);
    check_csr("rst2_status", 3, 32'h2);
    check_csr("rst2_level", 2, 0);
    csr_wr(3, 32'h3);

    // Randomized stream with concurrent releases
    for (int step = 0; step < 400; step++) begin
      v   = ($urandom_range(0, 3) != 0);
      sop = (m_pos < 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
      rq  = ($urandom_range(0, 4) == 0);
      n   = $urandom_range(0, 6);
      wd  = $urandom;
      bus.snk_valid = v; bus.snk_sop = sop; bus.snk_data = wd;
      bus.csr_write = rq; bus.csr_address = 2'd2; bus.csr_writedata = 32'(n);
      rel = rq ? m_rel_amount(n) : 0;
      tick();
      if (v && m_en) m_sample(sop, wd);
      m_level -= rel;
      m_rd = (m_rd + rel) % DEPTH;
      bus.snk_valid = 0; bus.snk_sop = 0; bus.csr_write = 0;
      if (step % 50 == 49) begin
        check_csr("rnd_level", 2, 32'(m_level));
        check_csr("rnd_wrptr", 1, 32'(m_wr));
        check_csr("rnd_status", 3, m_status());
      end
    end
    for (int a = 0; a < DEPTH; a++) if (m_known[a]) s1_check("rnd_ram", a);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
